// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH cycles per product, LSB first.
// Ports: clk, reset (async high), start, A, B in; busy, done, P (2*WIDTH) out.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_multiplier #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     result;
    logic              last_bit;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
    always_comb begin
        a_mag = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
        b_mag = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
        neg_d = neg_q;
        if (state_q == IDLE && start) begin
            neg_d = A[WIDTH-1] ^ B[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign result = neg_q ? (PW'(0) - acc_sum) : acc_sum;
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
    end

    assign result = acc_sum;
`endif

    assign last_bit = (cnt_q == CNT_LAST);
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                // P only ever sees the finished product.
                if (last_bit) begin
                    p_d   = result;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        P    = p_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=3.
// Follows SEQ_MULT_SIGNED_EN to pick signed or unsigned expectations.
module tb_seq_multiplier;

    localparam int W = 3;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vt[5];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        int sa;
        int sb;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        return (2*W)'(sa * sb);
`else
        return (2*W)'(int'(a) * int'(b));
`endif
    endfunction

    // One full transaction with cycle-accurate busy/done/P checks.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        for (int i = 0; i < W; i++) begin
            chk("run_busy", 64'(busy), 64'(1));
            chk("run_done", 64'(done), 64'(0));
            @(negedge clk);
        end
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_p", 64'(P), 64'(exp));
        @(negedge clk);
        chk("done_width", 64'(done), 64'(0));
        chk("p_hold", 64'(P), 64'(exp));
    endtask

    initial begin
`ifdef SEQ_MULT_SIGNED_EN
        vt[0] = '{a: 3'b111, b: 3'b011, p: 6'b111101};
        vt[1] = '{a: 3'b100, b: 3'b100, p: 6'b010000};
        vt[2] = '{a: 3'b100, b: 3'b011, p: 6'b110100};
        vt[3] = '{a: 3'b111, b: 3'b111, p: 6'd1};
        vt[4] = '{a: 3'b011, b: 3'b011, p: 6'd9};
`else
        vt[0] = '{a: 3'd7, b: 3'd7, p: 6'd49};
        vt[1] = '{a: 3'd0, b: 3'd5, p: 6'd0};
        vt[2] = '{a: 3'd7, b: 3'd0, p: 6'd0};
        vt[3] = '{a: 3'd4, b: 3'd6, p: 6'd24};
        vt[4] = '{a: 3'd3, b: 3'd5, p: 6'd15};
`endif
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_p", 64'(P), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].p);
        end

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_op(W'(a), W'(b), model(W'(a), W'(b)));
            end
        end

        // start held high: one result every W+2 cycles, A changed mid-RUN.
        @(negedge clk);
        A = 3'd5;
        B = 3'd3;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("b2b_done", 64'(done), 64'((c % 5) == 4));
            chk("b2b_busy", 64'(busy),
                64'((c % 5) >= 1 && (c % 5) <= 3));
            if (c == 4 || c == 9) begin
                chk("b2b_p", 64'(P), 64'(model(3'd5, 3'd3)));
            end
            if (c == 14) begin
                chk("b2b_p_last", 64'(P), 64'(model(3'd2, 3'd3)));
                start = 1'b0;
            end
            if (c == 7) begin
                A = 3'd2;
            end
        end

        // Reset in the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        A = 3'd6;
        B = 3'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        chk("pre_rst_p", 64'(P), 64'(model(3'd2, 3'd3)));
        reset = 1'b1;
        #1;
        chk("abort_p", 64'(P), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'(0));
            chk("abort_idle", 64'(busy), 64'(0));
        end
        run_op(3'd2, 3'd3, 6'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
